ask_fsk_symbol_sequencer: RTL and testbench

- Sequences the carrier frequency divider on a symbol-by-symbol basis.
- Accepts a serial bit stream over a valid/ready handshake.
- For each bit, it selects the divider code (msb + 3-bit cnt) and drives the divider load/hold control.
- Holds each symbol for a fixed number of clocks and gates the carrier for ASK.
- Sits between the bit source (framer/shift register) and the frequency divider plus the output stage.

---
 rtl/ask_fsk_symbol_sequencer.sv | 101 ++++++++++
 tb/tb_ask_fsk_symbol_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ask_fsk_symbol_sequencer.sv
// ASK/FSK symbol sequencer: takes one bit per symbol over valid/ready,
// selects the divider code, holds the symbol for SYM_CYCLES and gates the carrier.
module ask_fsk_symbol_sequencer #(
    parameter int          SYM_CYCLES = 1024,
    parameter logic [3:0]  F0_CODE    = 4'b0100,
    parameter logic [3:0]  F1_CODE    = 4'b1000,
    parameter int          CW         = $clog2(SYM_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       bit_ready,
    output logic       div_load,
    output logic       div_msb,
    output logic [2:0] div_cnt,
    output logic       carrier_en,
    output logic       sym_done,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] counter;
    logic          mode_q;
    logic          bit_q;
    logic [3:0]    code_q;
    logic          last;
    logic          xfer;
    logic          gate;

    assign last      = (state == SEND) && (counter == '0);
    assign bit_ready = (state == IDLE) || last;
    assign xfer      = bit_valid && bit_ready;
    assign gate      = mode_q ? bit_q : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        div_load   = 1'b1;
        busy       = 1'b0;
        sym_done   = 1'b0;
        carrier_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer)
                    state_nx = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                carrier_en = gate;
                state_nx   = SEND;
            end
            SEND: begin
                div_load   = 1'b0;
                busy       = 1'b1;
                carrier_en = gate;
                sym_done   = last;
                if (last)
                    state_nx = xfer ? LOAD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // LOAD counts as the first symbol cycle, so SEND runs SYM_CYCLES-1 cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            counter <= '0;
        else if (state == LOAD)
            counter <= CW'(SYM_CYCLES - 2);
        else if (state == SEND && counter != '0)
            counter <= counter - 1'b1;
    end

    // Code is latched at acceptance so it is already valid in the LOAD cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q  <= 1'b0;
            mode_q <= 1'b0;
            code_q <= F0_CODE;
        end else if (xfer) begin
            bit_q  <= bit_in;
            mode_q <= mode;
            code_q <= (mode || bit_in) ? F1_CODE : F0_CODE;
        end
    end

    assign div_msb = code_q[3];
    assign div_cnt = code_q[2:0];

endmodule

// File: tb/tb_ask_fsk_symbol_sequencer.sv
// Bench for ask_fsk_symbol_sequencer: directed scenarios plus random traffic
// compared each cycle against a symbol-position reference model.
module tb_ask_fsk_symbol_sequencer;

    localparam int         SYM = 8;
    localparam logic [3:0] F0  = 4'b0100;
    localparam logic [3:0] F1  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_ready;
    logic       div_load;
    logic       div_msb;
    logic [2:0] div_cnt;
    logic       carrier_en;
    logic       sym_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: position inside the current symbol (0 = idle, 1..SYM)
    int         pos = 0;
    logic       m_bit = 1'b0;
    logic       m_mode = 1'b0;
    logic [3:0] m_code = F0;
    int         busy_cnt = 0;
    int         done_cnt = 0;

    ask_fsk_symbol_sequencer #(.SYM_CYCLES(SYM)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .div_load   (div_load),
        .div_msb    (div_msb),
        .div_cnt    (div_cnt),
        .carrier_en (carrier_en),
        .sym_done   (sym_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return (pos == 0) || (pos == SYM);
    endfunction

    task automatic check_all();
        chk("bit_ready", bit_ready, m_ready());
        chk("div_load", div_load, pos <= 1);
        chk("busy", busy, pos != 0);
        chk("sym_done", sym_done, pos == SYM);
        chk("carrier_en", carrier_en, (pos != 0) && (m_mode ? m_bit : 1'b1));
        chk("code", {div_msb, div_cnt}, m_code);
        if (busy === 1'b1) busy_cnt++;
        if (sym_done === 1'b1) done_cnt++;
    endtask

    task automatic model_reset();
        pos    = 0;
        m_bit  = 1'b0;
        m_mode = 1'b0;
        m_code = F0;
    endtask

    // One clock: drive inputs, advance model at the edge, check at negedge
    task automatic cycle(input logic v, input logic b, input logic m,
                         output logic acc);
        bit_valid = v;
        bit_in    = b;
        mode      = m;
        acc       = v && m_ready();
        @(posedge clk);
        if (acc) begin
            pos    = 1;
            m_bit  = b;
            m_mode = m;
            m_code = (m || b) ? F1 : F0;
        end else if (pos == SYM) begin
            pos = 0;
        end else if (pos != 0) begin
            pos++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input logic m);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, m, acc);
    endtask

    task automatic send(input logic b, input logic m);
        logic acc;
        int   guard;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 4 * SYM) begin
            cycle(1'b1, b, m, acc);
            guard++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Reset asserted while a bit is offered: reset must win immediately
    task automatic pulse_reset();
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        rst       = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst       = 1'b0;
        bit_valid = 1'b0;
    endtask

    initial begin
        logic acc;
        logic pend;
        logic pbit;
        @(negedge clk);
        check_all();
        rst = 1'b0;

        idle(20, 1'b0);

        busy_cnt = 0;
        done_cnt = 0;
        send(1'b1, 1'b0);
        idle(10, 1'b0);
        chk("single_busy_len", busy_cnt, 8);
        chk("single_done_cnt", done_cnt, 1);

        busy_cnt = 0;
        done_cnt = 0;
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        idle(10, 1'b0);
        chk("stream_busy_len", busy_cnt, 24);
        chk("stream_done_cnt", done_cnt, 3);

        busy_cnt = 0;
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        idle(10, 1'b1);
        chk("ask_busy_len", busy_cnt, 16);

        send(1'b0, 1'b0);
        idle(3, 1'b1);
        send(1'b1, 1'b1);
        idle(10, 1'b0);

        send(1'b1, 1'b0);
        idle(4, 1'b0);
        pulse_reset();
        busy_cnt = 0;
        send(1'b0, 1'b0);
        idle(10, 1'b0);
        chk("post_rst_busy_len", busy_cnt, 8);

        pend = 1'b0;
        pbit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
                pend = 1'b0;
            end
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                pbit = 1'($urandom_range(0, 1));
            end
            cycle(pend, pbit, 1'($urandom_range(0, 1)), acc);
            if (acc) pend = 1'b0;
        end
        idle(12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
